// File: rtl/divisor_shift_sub.sv
// Restoring shift-subtract divider: 2N-bit dividend / N-bit divisor -> N-bit quotient and remainder.
// St/Idle/Done handshake matches the shift-add multiplier so both can share one sequencer.
module divisor_shift_sub #(
  parameter int N = 4
) (
  input  logic           Clk,
  input  logic           Rst_n,
  input  logic           St,
  input  logic [2*N-1:0] Dividend,
  input  logic [N-1:0]   Divisor,
  output logic           Idle,
  output logic           Done,
  output logic           V,
  output logic [N-1:0]   Quotient,
  output logic [N-1:0]   Remainder
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHK,
    S_SH,
    S_SUB,
    S_DONE
  } state_t;

  state_t         state_reg, state_next;
  logic [2*N-1:0] acc_reg, acc_next;
  logic [N-1:0]   dsr_reg, dsr_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic           v_reg, v_next;
  logic           c_reg, c_next;

  // The shifted-out MSB is kept as bit N of the partial remainder so the compare never loses it.
  logic [N:0]     part;
  logic [N-1:0]   diff_lo;

  assign part    = {c_reg, acc_reg[2*N-1:N]};
  assign diff_lo = part[N-1:0] - dsr_reg;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_reg <= S_IDLE;
      acc_reg   <= '0;
      dsr_reg   <= '0;
      cnt_reg   <= '0;
      v_reg     <= 1'b0;
      c_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      dsr_reg   <= dsr_next;
      cnt_reg   <= cnt_next;
      v_reg     <= v_next;
      c_reg     <= c_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    dsr_next   = dsr_reg;
    cnt_next   = cnt_reg;
    v_next     = v_reg;
    c_next     = c_reg;
    case (state_reg)
      S_IDLE: begin
        if (St) begin
          acc_next   = Dividend;
          dsr_next   = Divisor;
          cnt_next   = '0;
          v_next     = 1'b0;
          state_next = S_CHK;
        end
      end
      S_CHK: begin
        // A high half >= divisor means the quotient needs more than N bits (also catches divide by 0).
        if (acc_reg[2*N-1:N] >= dsr_reg) begin
          v_next     = 1'b1;
          state_next = S_DONE;
        end else begin
          state_next = S_SH;
        end
      end
      S_SH: begin
        c_next     = acc_reg[2*N-1];
        acc_next   = {acc_reg[2*N-2:0], 1'b0};
        state_next = S_SUB;
      end
      S_SUB: begin
        if (part >= {1'b0, dsr_reg}) begin
          acc_next[2*N-1:N] = diff_lo;
          acc_next[0]       = 1'b1;
        end
        if (cnt_reg == CW'(N - 1)) begin
          state_next = S_DONE;
        end else begin
          cnt_next   = cnt_reg + CW'(1);
          state_next = S_SH;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign Idle      = (state_reg == S_IDLE);
  assign Done      = (state_reg == S_DONE);
  assign V         = v_reg;
  assign Quotient  = acc_reg[N-1:0];
  assign Remainder = acc_reg[2*N-1:N];

endmodule

// File: tb/tb_divisor_shift_sub.sv
// Directed bench for divisor_shift_sub (N=4): reset, divides, carry path, overflow,
// ignored St, mid-operation reset and back-to-back operation.
module tb_divisor_shift_sub;

  localparam int N = 4;

  logic           Clk;
  logic           Rst_n;
  logic           St;
  logic [2*N-1:0] Dividend;
  logic [N-1:0]   Divisor;
  logic           Idle;
  logic           Done;
  logic           V;
  logic [N-1:0]   Quotient;
  logic [N-1:0]   Remainder;

  int tests_run = 0;
  int tests_failed = 0;
  int idle_err = 0;

  divisor_shift_sub #(.N(N)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .St        (St),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .Idle      (Idle),
    .Done      (Done),
    .V         (V),
    .Quotient  (Quotient),
    .Remainder (Remainder)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Starts an operation (St sampled at e0) and returns the cycle in which Done is seen.
  // With toggle set, St and the operands are scrambled while the unit is busy.
  task automatic run_op(input logic [2*N-1:0] dvd, input logic [N-1:0] dsr,
                        input bit toggle, output int done_cyc);
    Dividend = dvd;
    Divisor  = dsr;
    St       = 1'b1;
    tick();
    St       = 1'b0;
    done_cyc = 0;
    idle_err = 0;
    for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
      if (Done) begin
        done_cyc = c;
      end else begin
        if (Idle) idle_err++;
        if (toggle) begin
          St       = 1'($urandom_range(0, 1));
          Dividend = 8'($urandom);
          Divisor  = 4'($urandom);
        end
        tick();
      end
    end
    St = 1'b0;
    $display("[TB] op %0d/%0d: done cycle %0d Q=%0d R=%0d V=%0d", dvd, dsr, done_cyc,
             Quotient, Remainder, V);
  endtask

  initial begin
    int dc;
    int first_done;
    int gap;

    // Reset with St asserted
    Rst_n    = 1'b0;
    St       = 1'b1;
    Dividend = 8'd135;
    Divisor  = 4'd13;
    tick();
    tick();
    check("rst_idle", 32'(Idle), 32'd1);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_v",    32'(V), 32'd0);
    check("rst_q",    32'(Quotient), 32'd0);
    check("rst_r",    32'(Remainder), 32'd0);
    St    = 1'b0;
    Rst_n = 1'b1;
    tick();
    check("rst_no_start", 32'(Idle), 32'd1);

    // Basic divide 135/13 = 10 r 5
    run_op(8'd135, 4'd13, 1'b0, dc);
    check("basic_done_cyc", 32'(dc), 32'd10);
    check("basic_idle_low", 32'(idle_err), 32'd0);
    check("basic_q", 32'(Quotient), 32'd10);
    check("basic_r", 32'(Remainder), 32'd5);
    check("basic_v", 32'(V), 32'd0);
    tick();
    check("basic_done_pulse", 32'(Done), 32'd0);
    check("basic_idle_back", 32'(Idle), 32'd1);
    Dividend = 8'd3;
    Divisor  = 4'd1;
    tick();
    tick();
    check("basic_hold_q", 32'(Quotient), 32'd10);
    check("basic_hold_r", 32'(Remainder), 32'd5);

    // Carry path 224/15 = 14 r 14
    run_op(8'd224, 4'd15, 1'b0, dc);
    check("carry_done_cyc", 32'(dc), 32'd10);
    check("carry_q", 32'(Quotient), 32'd14);
    check("carry_r", 32'(Remainder), 32'd14);
    check("carry_v", 32'(V), 32'd0);
    tick();

    // Overflow 255/15
    run_op(8'd255, 4'd15, 1'b0, dc);
    check("ovf_done_cyc", 32'(dc), 32'd2);
    check("ovf_v", 32'(V), 32'd1);
    tick();
    check("ovf_idle_c3", 32'(Idle), 32'd1);
    check("ovf_v_held", 32'(V), 32'd1);

    // Divide by zero 7/0
    run_op(8'd7, 4'd0, 1'b0, dc);
    check("dz_done_cyc", 32'(dc), 32'd2);
    check("dz_v", 32'(V), 32'd1);
    tick();
    check("dz_idle_c3", 32'(Idle), 32'd1);

    // Zero dividend with St/operands scrambled while busy
    run_op(8'd0, 4'd7, 1'b1, dc);
    check("zero_done_cyc", 32'(dc), 32'd10);
    check("zero_idle_low", 32'(idle_err), 32'd0);
    check("zero_q", 32'(Quotient), 32'd0);
    check("zero_r", 32'(Remainder), 32'd0);
    check("zero_v", 32'(V), 32'd0);
    tick();
    check("zero_idle_back", 32'(Idle), 32'd1);

    // Reset during cycle 5 of a divide
    Dividend = 8'd135;
    Divisor  = 4'd13;
    St       = 1'b1;
    tick();
    St = 1'b0;
    for (int c = 1; c < 5; c++) tick();
    check("mid_busy", 32'(Idle), 32'd0);
    Rst_n = 1'b0;
    tick();
    check("mid_idle", 32'(Idle), 32'd1);
    check("mid_done", 32'(Done), 32'd0);
    check("mid_q", 32'(Quotient), 32'd0);
    check("mid_r", 32'(Remainder), 32'd0);
    check("mid_v", 32'(V), 32'd0);
    Rst_n = 1'b1;
    dc = 0;
    for (int c = 0; c < 12; c++) begin
      if (Done) dc++;
      tick();
    end
    check("mid_no_done", 32'(dc), 32'd0);

    // Back-to-back with St held high: 135/13 then 100/9
    Dividend   = 8'd135;
    Divisor    = 4'd13;
    St         = 1'b1;
    first_done = 0;
    gap        = 0;
    for (int c = 0; c <= 40 && gap == 0; c++) begin
      if (Done) begin
        if (first_done == 0) begin
          first_done = c;
          check("b2b_first_q", 32'(Quotient), 32'd10);
          check("b2b_first_r", 32'(Remainder), 32'd5);
          Dividend = 8'd100;
          Divisor  = 4'd9;
        end else begin
          gap = c - first_done;
        end
      end
      if (gap == 0) tick();
    end
    St = 1'b0;
    $display("[TB] back-to-back: first done cycle %0d gap %0d Q=%0d R=%0d", first_done, gap,
             Quotient, Remainder);
    check("b2b_first_cyc", 32'(first_done), 32'd10);
    check("b2b_gap", 32'(gap), 32'd11);
    check("b2b_second_q", 32'(Quotient), 32'd11);
    check("b2b_second_r", 32'(Remainder), 32'd1);
    check("b2b_second_v", 32'(V), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
